demux_scan_ctrl: RTL and testbench
==================================

// Module: demux_scan_ctrl
// PURPOSE
// Upstream sequencer for the 1-to-8, 4-bit output demux.
// Walks the demux select S through the enabled channels in ascending order and holds each channel for DIV clock cycles.
// Latches a fresh data word A on entry to each channel and drives the demux enable C4.
// Reports frame completion, frame count and start errors to the control logic.
// PARAMETERS
// DATA_W  4  width of data word A / data_in
// N_CH    8  number of demux channels (mask width)
// SEL_W   3  select width; 2**SEL_W >= N_CH
// DIV     4  dwell cycles per channel; legal range 1..255
// PORTS
// clk         in   1       system clock; all logic on rising edge
// rst         in   1       synchronous reset, active-low
// start       in   1       request one scan frame; sampled only in IDLE
// stop        in   1       request halt at end of current dwell
// ch_mask     in   N_CH    channel enable mask; bit i enables channel i
// data_in     in   DATA_W  source word; sampled at channel entry
// A           out  DATA_W  data word to demux
// S           out  SEL_W   channel select to demux
// C4          out  1       demux enable; 1 only while scanning
// busy        out  1       1 in SCAN state
// frame_done  out  1       one-cycle pulse at end of frame
// frame_cnt   out  8       completed-frame counter; wraps 255->0
// start_err   out  1       one-cycle pulse: start with ch_mask==0
// BEHAVIOUR
// - All outputs registered.
// - Reset (rst==0 at an edge), including mid-scan, forces:
//   - state IDLE;
//   - A=0, S=0, C4=0, busy=0, frame_done=0, frame_cnt=0, start_err=0;
//   - dwell counter 0, latched mask 0.
// - States: IDLE, SCAN.
// - IDLE->SCAN: start=1, stop=0 and ch_mask!=0 at an edge.
//   - ch_mask is latched.
//   - S <= lowest set bit, A <= data_in, C4 <= 1, busy <= 1.
//   - Latency: 1 cycle from the edge that samples start.
// - IDLE start errors:
//   - start=1 with ch_mask==0: stay IDLE, start_err=1 for 1 cycle.
//   - start=1 together with stop=1: stop dominates; stay IDLE, no start_err.
// - stop=1 in IDLE: no effect.
// - SCAN dwell: dwell counter 0..DIV-1; S and A are held stable for exactly DIV cycles.
//   DIV=1 gives a new channel every cycle.
// - At dwell end with a higher enabled channel in the latched mask:
//   - S <= that channel, A <= data_in, dwell restarts at 0;
//   - C4 stays 1 (no gap cycle).
// - At dwell end on the highest enabled channel:
//   - frame_done=1 for 1 cycle and frame_cnt increments, in the same cycle;
//   - then the CONFIGURATION rule applies.
// - stop=1 in SCAN is latched (sticky) until the current dwell ends. At that dwell end:
//   - ->IDLE with C4=0, busy=0, S=0, A=0;
//   - frame_done=1 only if that dwell closed the frame.
// - start in SCAN is ignored. ch_mask changes in SCAN are ignored until the next frame start.
// - Idle output values: S=0, A=0, C4=0.
// CONFIGURATION
// - DEMUX_SCAN_CONT_EN defined (continuous mode):
//   - at frame end, re-latch ch_mask and restart from its lowest set bit with no gap cycle;
//   - if the re-latched mask is 0, go to IDLE (no start_err);
//   - the scan runs until stop or reset.
// - DEMUX_SCAN_CONT_EN undefined (one-shot mode):
//   - at frame end, go to IDLE; C4=0 in the cycle after the last dwell.
// TESTING
// 1. Full frame: DIV=4, ch_mask=8'hFF, data_in=4'b0110, start pulse.
//    -> C4=1 for 32 cycles; S=0..7, each held 4 cycles; A=4'b0110.
//    -> frame_done pulses once; frame_cnt=1; one-shot build then returns to IDLE.
// 2. Masked channels: ch_mask=8'b1010_0100, DIV=2.
//    -> S sequence 2,5,7, each for 2 cycles; frame_done after 6 scan cycles.
// 3. Mid-scan reset: rst=0 while S=3.
//    -> next cycle all outputs 0, state IDLE.
//    -> a start after rst=1 begins again at the lowest enabled channel.
// 4. Stop and start errors:
//    - stop=1 at dwell count 1 of channel 4 (DIV=4) -> exits after that dwell, no frame_done.
//    - start with ch_mask=0 -> start_err=1 for 1 cycle, C4 stays 0.
// 5. Data per channel: data_in increments every cycle, DIV=3.
//    -> A updates only on channel entry, equal to data_in at the entry edge.
// 6. DEMUX_SCAN_CONT_EN build: ch_mask=8'h81, DIV=1.
//    -> S toggles 0,7,0,7...; frame_done every 2 cycles; frame_cnt wraps 255->0.
//    -> stop -> IDLE.

Source files
------------

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer for the 1-to-8 output demux: walks S through the enabled channels, dwelling DIV cycles each.
// Optional continuous scanning is enabled by defining DEMUX_SCAN_CONT_EN (one-shot frames otherwise).
module demux_scan_ctrl #(
    parameter int DATA_W = 4,
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] A,
    output logic [SEL_W-1:0]  S,
    output logic              C4,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              start_err
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DIV - 1);

    state_t            state, state_n;
    logic [7:0]        dwell, dwell_n;
    logic [N_CH-1:0]   mask_l, mask_n;
    logic              stop_l, stop_n;
    logic [DATA_W-1:0] a_n;
    logic [SEL_W-1:0]  s_n;
    logic              c4_n, busy_n, fd_n, se_n;
    logic [7:0]        cnt_n;
    logic [N_CH-1:0]   higher;
    logic              dwell_end, enter, go_idle;
    logic [SEL_W-1:0]  enter_ch;

    function automatic logic [SEL_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Enabled channels strictly above the current select.
    function automatic logic [N_CH-1:0] above(input logic [N_CH-1:0] m, input logic [SEL_W-1:0] cur);
        logic [N_CH-1:0] r;
        for (int i = 0; i < N_CH; i++) begin
            r[i] = m[i] && (i > int'(cur));
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            dwell      <= '0;
            mask_l     <= '0;
            stop_l     <= 1'b0;
            A          <= '0;
            S          <= '0;
            C4         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            start_err  <= 1'b0;
        end else begin
            state      <= state_n;
            dwell      <= dwell_n;
            mask_l     <= mask_n;
            stop_l     <= stop_n;
            A          <= a_n;
            S          <= s_n;
            C4         <= c4_n;
            busy       <= busy_n;
            frame_done <= fd_n;
            frame_cnt  <= cnt_n;
            start_err  <= se_n;
        end
    end

    always_comb begin
        state_n   = state;
        dwell_n   = dwell;
        mask_n    = mask_l;
        stop_n    = stop_l;
        a_n       = A;
        s_n       = S;
        c4_n      = C4;
        busy_n    = busy;
        fd_n      = 1'b0;
        se_n      = 1'b0;
        cnt_n     = frame_cnt;
        enter     = 1'b0;
        enter_ch  = '0;
        go_idle   = 1'b0;
        higher    = above(mask_l, S);
        dwell_end = (dwell == DWELL_LAST);

        unique case (state)
            IDLE: begin
                // stop dominates a simultaneous start
                if (start && !stop) begin
                    if (ch_mask != '0) begin
                        state_n  = SCAN;
                        mask_n   = ch_mask;
                        stop_n   = 1'b0;
                        enter    = 1'b1;
                        enter_ch = lowest_ch(ch_mask);
                    end else begin
                        se_n = 1'b1;
                    end
                end
            end
            SCAN: begin
                stop_n = stop_l | stop;
                if (!dwell_end) begin
                    dwell_n = dwell + 8'd1;
                end else begin
                    if (higher == '0) begin
                        fd_n  = 1'b1;
                        cnt_n = frame_cnt + 8'd1;
                    end
                    if (stop_l || stop) begin
                        go_idle = 1'b1;
                    end else if (higher != '0) begin
                        enter    = 1'b1;
                        enter_ch = lowest_ch(higher);
                    end else begin
`ifdef DEMUX_SCAN_CONT_EN
                        if (ch_mask != '0) begin
                            mask_n   = ch_mask;
                            enter    = 1'b1;
                            enter_ch = lowest_ch(ch_mask);
                        end else begin
                            go_idle = 1'b1;
                        end
`else
                        go_idle = 1'b1;
`endif
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        // Channel entry: new select, fresh data word, dwell restarts.
        if (enter) begin
            s_n     = enter_ch;
            a_n     = data_in;
            c4_n    = 1'b1;
            busy_n  = 1'b1;
            dwell_n = '0;
        end

        if (go_idle) begin
            state_n = IDLE;
            a_n     = '0;
            s_n     = '0;
            c4_n    = 1'b0;
            busy_n  = 1'b0;
            dwell_n = '0;
            mask_n  = '0;
            stop_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Bench for demux_scan_ctrl: four instances (DIV=1..4) share stimulus and are checked every cycle against a channel-list model.
module tb_demux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] ch_mask = 8'h00;
    logic [3:0] data_in = 4'h0;

    logic [3:0] a_o   [4];
    logic [2:0] s_o   [4];
    logic       c4_o  [4];
    logic       busy_o[4];
    logic       fd_o  [4];
    logic [7:0] cnt_o [4];
    logic       se_o  [4];

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        demux_scan_ctrl #(.DATA_W(4), .N_CH(8), .SEL_W(3), .DIV(g + 1)) dut (
            .clk(clk), .rst(rst), .start(start), .stop(stop),
            .ch_mask(ch_mask), .data_in(data_in),
            .A(a_o[g]), .S(s_o[g]), .C4(c4_o[g]), .busy(busy_o[g]),
            .frame_done(fd_o[g]), .frame_cnt(cnt_o[g]), .start_err(se_o[g])
        );
    end

    // Model: a list of enabled channels, a position in it and a countdown of remaining dwell cycles.
    int         m_act [4];
    int         m_n   [4];
    int         m_idx [4];
    int         m_rem [4];
    int         m_stop[4];
    int         m_ch  [4][8];
    logic [3:0] e_a   [4];
    logic [2:0] e_s   [4];
    logic       e_c4  [4];
    logic       e_busy[4];
    logic       e_fd  [4];
    logic [7:0] e_cnt [4];
    logic       e_se  [4];

    task automatic m_enter(input int k);
        e_s[k]    = 3'(m_ch[k][m_idx[k]]);
        e_a[k]    = data_in;
        e_c4[k]   = 1'b1;
        e_busy[k] = 1'b1;
        m_rem[k]  = k + 1;
    endtask

    task automatic m_load(input int k);
        m_n[k] = 0;
        for (int i = 0; i < 8; i++) begin
            if (ch_mask[i]) begin
                m_ch[k][m_n[k]] = i;
                m_n[k]++;
            end
        end
        m_idx[k] = 0;
        m_act[k] = 1;
        m_enter(k);
    endtask

    task automatic m_idle(input int k);
        m_act[k]  = 0;
        m_stop[k] = 0;
        e_a[k]    = 4'h0;
        e_s[k]    = 3'h0;
        e_c4[k]   = 1'b0;
        e_busy[k] = 1'b0;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            e_fd[k] = 1'b0;
            e_se[k] = 1'b0;
            if (!rst) begin
                m_idle(k);
                e_cnt[k] = 8'h00;
            end else if (m_act[k] == 0) begin
                if (start && !stop) begin
                    if (ch_mask != 8'h00) begin
                        m_stop[k] = 0;
                        m_load(k);
                    end else begin
                        e_se[k] = 1'b1;
                    end
                end
            end else begin
                if (stop) m_stop[k] = 1;
                m_rem[k]--;
                if (m_rem[k] == 0) begin
                    if (m_idx[k] == m_n[k] - 1) begin
                        e_fd[k]  = 1'b1;
                        e_cnt[k] = e_cnt[k] + 8'd1;
                    end
                    if (m_stop[k] != 0) begin
                        m_idle(k);
                    end else if (m_idx[k] < m_n[k] - 1) begin
                        m_idx[k]++;
                        m_enter(k);
                    end else begin
`ifdef DEMUX_SCAN_CONT_EN
                        if (ch_mask != 8'h00) m_load(k);
                        else m_idle(k);
`else
                        m_idle(k);
`endif
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                logic [18:0] act, exp;
                act = {a_o[k], s_o[k], c4_o[k], busy_o[k], fd_o[k], cnt_o[k], se_o[k]};
                exp = {e_a[k], e_s[k], e_c4[k], e_busy[k], e_fd[k], e_cnt[k], e_se[k]};
                tests++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL model_div%0d at %0t: got {A,S,C4,busy,fd,cnt,se}=%h expected %h",
                             k + 1, $time, act, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pulse start for one sampling edge; returns at the first cycle after that edge (t=0).
    task automatic pulse_start(input logic [7:0] m, input logic [3:0] d);
        ch_mask = m;
        data_in = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        ch_mask = 8'h00;
    endtask

    int c4c, fdc;
    logic wrap_seen;
    logic [7:0] prev_cnt;

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {a_o[3], s_o[3], c4_o[3], busy_o[3], fd_o[3], cnt_o[3], se_o[3]}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Full frame, DIV=4, all channels
        pulse_start(8'hFF, 4'b0110);
        c4c = 0;
        fdc = 0;
        for (int t = 0; t < 40; t++) begin
            if (c4_o[3]) c4c++;
            if (fd_o[3]) fdc++;
            if (t == 13) begin
                chk("t1_s_at13", 32'(s_o[3]), 32'd3);
                chk("t1_a_at13", 32'(a_o[3]), 32'b0110);
            end
            @(negedge clk);
        end
        chk("t1_c4_cycles", c4c, 32'd32);
        chk("t1_frame_done_pulses", fdc, 32'd1);
        chk("t1_frame_cnt", 32'(cnt_o[3]), 32'd1);
        chk("t1_idle_busy", 32'(busy_o[3]), 32'd0);

        // Masked channels, DIV=2: S = 2,5,7
        pulse_start(8'b1010_0100, 4'h3);
        c4c = 0;
        for (int t = 0; t < 10; t++) begin
            if (c4_o[1]) c4c++;
            if (t == 0) chk("t2_s_at0", 32'(s_o[1]), 32'd2);
            if (t == 2) chk("t2_s_at2", 32'(s_o[1]), 32'd5);
            if (t == 5) chk("t2_s_at5", 32'(s_o[1]), 32'd7);
            if (t == 6) chk("t2_fd_at6", 32'(fd_o[1]), 32'd1);
            @(negedge clk);
        end
        chk("t2_c4_cycles", c4c, 32'd6);
        repeat (30) @(negedge clk);

        // Mid-scan reset while S=3, then restart
        pulse_start(8'hFF, 4'hA);
        for (int i = 0; i < 40 && s_o[3] != 3'd3; i++) @(negedge clk);
        chk("t3_reach_s3", 32'(s_o[3]), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        chk("t3_after_reset", {a_o[3], s_o[3], c4_o[3], busy_o[3], fd_o[3], cnt_o[3], se_o[3]}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        pulse_start(8'b0001_1000, 4'h5);
        chk("t3_restart_s", 32'(s_o[3]), 32'd3);
        chk("t3_restart_c4", 32'(c4_o[3]), 32'd1);
        repeat (40) @(negedge clk);

        // Stop at dwell count 1 of channel 4, DIV=4
        pulse_start(8'hFF, 4'h9);
        fdc = 0;
        for (int t = 0; t < 22; t++) begin
            if (t == 17) stop = 1'b1;
            if (t == 18) stop = 1'b0;
            if (t >= 16 && fd_o[3]) fdc++;
            if (t == 19) chk("t4_hold_s4", {28'h0, c4_o[3], s_o[3]}, {28'h0, 1'b1, 3'd4});
            if (t == 20) chk("t4_exit", {29'h0, c4_o[3], busy_o[3], fd_o[3]}, 32'h0);
            @(negedge clk);
        end
        chk("t4_no_frame_done", fdc, 32'd0);
        repeat (10) @(negedge clk);

        ch_mask = 8'h00;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("t4_start_err", {30'h0, se_o[3], c4_o[3]}, 32'b10);
        @(negedge clk);
        chk("t4_start_err_single", 32'(se_o[3]), 32'd0);

        ch_mask = 8'hFF;
        start   = 1'b1;
        stop    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        stop    = 1'b0;
        ch_mask = 8'h00;
        chk("t4_start_with_stop", {30'h0, se_o[3], c4_o[3]}, 32'h0);
        @(negedge clk);

        // Data per channel, DIV=3, data_in incrementing every cycle
        pulse_start(8'hFF, 4'd5);
        for (int t = 0; t < 30; t++) begin
            if (t == 0) chk("t5_a_entry0", 32'(a_o[2]), 32'd5);
            if (t == 2) chk("t5_a_held", 32'(a_o[2]), 32'd5);
            if (t == 3) chk("t5_a_entry1", 32'(a_o[2]), 32'd8);
            data_in = data_in + 4'd1;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);

`ifdef DEMUX_SCAN_CONT_EN
        // Continuous mode, DIV=1, channels 0 and 7
        ch_mask = 8'h81;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("t6_s_at0", 32'(s_o[0]), 32'd0);
        @(negedge clk);
        chk("t6_s_at1", 32'(s_o[0]), 32'd7);
        @(negedge clk);
        chk("t6_wrap_in_frame", {28'h0, fd_o[0], c4_o[0], s_o[0][0], 1'b0}, {28'h0, 4'b1100});
        repeat (20) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t6_stop_idle", {30'h0, c4_o[0], busy_o[0]}, 32'h0);
        repeat (10) @(negedge clk);
`endif

        // frame_cnt wrap: DIV=1, one channel, start held
        ch_mask   = 8'h01;
        start     = 1'b1;
        wrap_seen = 1'b0;
        prev_cnt  = cnt_o[0];
        for (int i = 0; i < 700 && !wrap_seen; i++) begin
            @(negedge clk);
            if (prev_cnt == 8'hFF && cnt_o[0] == 8'h00) wrap_seen = 1'b1;
            prev_cnt = cnt_o[0];
        end
        chk("t6_frame_cnt_wrap", 32'(wrap_seen), 32'd1);
        start   = 1'b0;
        ch_mask = 8'h00;
        repeat (12) @(negedge clk);
        chk("end_idle", {30'h0, c4_o[3], busy_o[3]}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
